// File: rtl/xor_cipher_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_pkg
// Shared types and constants for the XOR cipher pipeline stages.
//   byte_t                 : one data/key byte
//   state_e                : sequencer state (IDLE / WAIT_DONE / WAIT_REL)
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit for a stalled core
//   rotl1()                : rotate a byte left by one (rolling-key helper)
// ---------------------------------------------------------------------------
package xor_cipher_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_WAIT_REL  = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 32;

    function automatic byte_t rotl1(input byte_t b);
        return {b[6:0], b[7]};
    endfunction

endpackage

// File: rtl/xor_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// xor_stream_ctrl_if
// Bundles the three handshakes around the sequencer:
//   plaintext stream  : in_valid / in_data / in_ready
//   ciphertext stream : out_valid / out_data / out_ready
//   cipher core       : core_start / core_plaintext / core_key /
//                       core_ciphertext / core_done
// Stream handshakes: a byte moves on a rising clock edge where valid and
// ready are both high; valid, once raised, holds with stable data until that
// edge, and ready may depend combinationally on valid.
// Core handshake: level-held start/done; start stays high with stable
// operands until done is seen, and the next start only follows done low.
// Modports:
//   master : the sequencer (drives in_ready, out_*, core_start/operands)
//   slave  : the environment (sources, sinks and the cipher core)
// ---------------------------------------------------------------------------
interface xor_stream_ctrl_if;
    import xor_cipher_pkg::*;

    logic  in_valid;
    byte_t in_data;
    logic  in_ready;

    logic  out_valid;
    byte_t out_data;
    logic  out_ready;

    logic  core_start;
    byte_t core_plaintext;
    byte_t core_key;
    byte_t core_ciphertext;
    logic  core_done;

    modport master (
        input  in_valid, in_data, out_ready, core_ciphertext, core_done,
        output in_ready, out_valid, out_data, core_start, core_plaintext, core_key
    );

    modport slave (
        output in_valid, in_data, out_ready, core_ciphertext, core_done,
        input  in_ready, out_valid, out_data, core_start, core_plaintext, core_key
    );

endinterface

// File: rtl/xor_out_reg.sv
// ---------------------------------------------------------------------------
// xor_out_reg
// One-entry valid/ready output register with a delivered-byte counter.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   load_i         : capture load_data_i this cycle (caller only loads when
//                    can_load_o is high, so an unaccepted byte is never lost)
//   load_data_i    : byte to capture
//   out_ready_i    : downstream ready
//   out_valid_o    : register holds a byte
//   out_data_o     : held byte
//   byte_count_o   : bytes handed downstream, wraps modulo 2^CNT_W
//   can_load_o     : register is empty or empties this cycle
// ---------------------------------------------------------------------------
module xor_out_reg
    import xor_cipher_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  byte_t            load_data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output byte_t            out_data_o,
    output logic [CNT_W-1:0] byte_count_o,
    output logic             can_load_o
);

    logic             valid_q;
    byte_t            data_q;
    logic [CNT_W-1:0] count_q;
    logic             handshake;

    assign handshake  = valid_q && out_ready_i;
    assign can_load_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            // A load in the same cycle as a handshake reloads the register,
            // so valid stays high while the old byte is counted out.
            if (load_i) begin
                valid_q <= 1'b1;
                data_q  <= load_data_i;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (handshake) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign byte_count_o = count_q;

endmodule

// File: rtl/xor_stream_ctrl.sv
// ---------------------------------------------------------------------------
// xor_stream_ctrl
// Upstream sequencer for the bitwise XOR cipher core. Accepts plaintext
// bytes, runs the core's level start/done handshake one byte at a time,
// captures each ciphertext into a one-entry output register and watches the
// core with a timeout.
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in WAIT_DONE/WAIT_REL before abort (>=16)
//   CNT_W          : width of byte_count
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   key_load       : load key_in into the key register (IDLE only)
//   key_in         : session key
//   bus            : plaintext, ciphertext and core handshakes (master side)
//   busy           : not IDLE, or an output byte is pending
//   timeout_err    : sticky watchdog flag, cleared only by reset
//   byte_count     : bytes delivered downstream
//   dbg_state      : current sequencer state
// Build option:
//   XOR_KEY_ROTATE_EN : rotate the key left by one after every successful
//                       capture (rolling per-byte key); key_load restarts it.
// ---------------------------------------------------------------------------
module xor_stream_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_load,
    input  byte_t               key_in,
    xor_stream_ctrl_if.master   bus,
    output logic                busy,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    byte_count,
    output state_e              dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    byte_t             key_q, key_d;
    byte_t             pt_q, pt_d;
    byte_t             ck_q, ck_d;
    logic              start_q, start_d;
    logic              terr_q, terr_d;

    logic              in_ready;
    logic              capture;
    logic              can_capture;
    logic              out_valid;
    logic              wd_expire;

    // in_ready is forced low during reset so every output reads 0 there.
    assign in_ready  = !reset && (state_q == ST_IDLE) && !key_load && !bus.core_done;
    assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        key_d   = key_q;
        pt_d    = pt_q;
        ck_d    = ck_q;
        start_d = start_q;
        terr_d  = terr_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    key_d = key_in;
                end else if (bus.in_valid && in_ready) begin
                    pt_d    = bus.in_data;
                    ck_d    = key_q;
                    start_d = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (bus.core_done) begin
                    // With the output register still full the core keeps its
                    // result while start stays high; the watchdog is frozen
                    // because the stall is downstream, not in the core.
                    if (can_capture) begin
                        capture = 1'b1;
                        start_d = 1'b0;
                        state_d = ST_WAIT_REL;
`ifdef XOR_KEY_ROTATE_EN
                        key_d   = rotl1(key_q);
`endif
                    end
                end else if (wd_expire) begin
                    terr_d  = 1'b1;
                    start_d = 1'b0;
                    state_d = ST_WAIT_REL;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            ST_WAIT_REL: begin
                // Waiting for done low keeps the next start clear of a stale
                // done; a core that never releases is abandoned on expiry.
                if (!bus.core_done || wd_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            ck_q    <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            ck_q    <= ck_d;
            start_q <= start_d;
            terr_q  <= terr_d;
        end
    end

    xor_out_reg #(
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (capture),
        .load_data_i  (bus.core_ciphertext),
        .out_ready_i  (bus.out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (bus.out_data),
        .byte_count_o (byte_count),
        .can_load_o   (can_capture)
    );

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.core_start     = start_q;
    assign bus.core_plaintext = pt_q;
    assign bus.core_key       = ck_q;

    assign busy        = (state_q != ST_IDLE) || out_valid;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_xor_stream_ctrl.sv
module tb_xor_stream_ctrl;
  import xor_cipher_pkg::*;

  localparam int CNT_W    = 16;
  localparam int CORE_LAT = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             key_load = 1'b0;
  logic [7:0]       key_in = 8'h00;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] byte_count;
  state_e           dbg_state;

  xor_stream_ctrl_if bus();

  xor_stream_ctrl #(.TIMEOUT_CYCLES(32), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_load    (key_load),
    .key_in      (key_in),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .byte_count  (byte_count),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- behavioural cipher core ----------------
  logic core_dead = 1'b0;
  initial begin
    int cnt;
    int rel;
    cnt = 0;
    rel = 0;
    bus.core_done = 1'b0;
    bus.core_ciphertext = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.core_done = 1'b0;
        cnt = 0;
        rel = 0;
      end else if (bus.core_start) begin
        rel = 0;
        cnt++;
        if (!core_dead && cnt >= CORE_LAT) begin
          bus.core_done = 1'b1;
          bus.core_ciphertext = bus.core_plaintext ^ bus.core_key;
        end
      end else begin
        cnt = 0;
        if (bus.core_done) begin
          rel++;
          if (rel >= 2) begin
            bus.core_done = 1'b0;
            rel = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] model_key = 8'h00;
  logic [7:0] cur_pt = 8'h00;
  logic [7:0] cur_key = 8'h00;
  int         exp_count = 0;
  logic       ov_prev = 1'b0;
  logic       drop_mode = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_count = 0;
      ov_prev   = 1'b0;
      model_key = 8'h00;
      cur_pt    = 8'h00;
      cur_key   = 8'h00;
    end else begin
      check("byte_count", 32'(byte_count), 32'(exp_count[CNT_W-1:0]));
      if (bus.core_start) begin
        check("core_plaintext", 32'(bus.core_plaintext), 32'(cur_pt));
        check("core_key", 32'(bus.core_key), 32'(cur_key));
        check("in_ready_while_busy", 32'(bus.in_ready), 32'(0));
      end
      if (bus.out_valid && !ov_prev)
        check("start_low_at_capture", 32'(bus.core_start), 32'(0));
      if (bus.out_valid && bus.out_ready) begin
        out_log.push_back(bus.out_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got 0x%0h with nothing expected", bus.out_data);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        exp_count++;
      end
      if (key_load) model_key = key_in;
      if (bus.in_valid && bus.in_ready) begin
        cur_pt  = bus.in_data;
        cur_key = model_key;
        if (!drop_mode) begin
          exp_q.push_back(bus.in_data ^ model_key);
`ifdef XOR_KEY_ROTATE_EN
          model_key = {model_key[6:0], model_key[7]};
`endif
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_key(input logic [7:0] k);
    key_load = 1'b1;
    key_in   = k;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail("send_byte");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && !bus.core_done;
    end
    @(posedge clk);
    #1;
    if (!ok) fail("wait_idle");
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] stream_in [4];
  logic [7:0] stream_exp [4];
  int ls;
  int n;
  int bc0;
  bit hit;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    // reset state
    cycles(3);
    @(negedge clk);
    check("rst_core_start", 32'(bus.core_start), 32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_byte_count", 32'(byte_count), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(2);

    // key load + one byte
    ls = out_log.size();
    load_key(8'h5A);
    send_byte(8'h3C);
    wait_idle();
    check("one_byte_count", 32'(out_log.size() - ls), 32'(1));
    if (out_log.size() > ls) check("one_byte_data", 32'(out_log[ls]), 32'(8'h66));
    @(negedge clk);
    check("one_byte_bc", 32'(byte_count), 32'(1));
    @(posedge clk);
    #1;

    // streaming
    stream_in = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
`ifdef XOR_KEY_ROTATE_EN
    stream_exp = '{8'h0F, 8'hE1, 8'h99, 8'h22};
`else
    stream_exp = '{8'h0F, 8'hF0, 8'hAA, 8'h55};
`endif
    ls = out_log.size();
    load_key(8'h0F);
    for (int i = 0; i < 4; i++) send_byte(stream_in[i]);
    wait_idle();
    check("stream_count", 32'(out_log.size() - ls), 32'(4));
    for (int i = 0; i < 4; i++)
      if (out_log.size() > ls + i) check("stream_data", 32'(out_log[ls+i]), 32'(stream_exp[i]));

    // backpressure: second result waits in the core, watchdog frozen
    ls = out_log.size();
    load_key(8'h21);
    bus.out_ready = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    cycles(35);
    @(negedge clk);
    check("bp_start_held", 32'(bus.core_start), 32'(1));
    check("bp_out_valid", 32'(bus.out_valid), 32'(1));
    check("bp_out_data", 32'(bus.out_data), 32'(8'h31));
    check("bp_no_timeout", 32'(timeout_err), 32'(0));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_idle();
    check("bp_count", 32'(out_log.size() - ls), 32'(2));
    if (out_log.size() > ls + 1) begin
      check("bp_first", 32'(out_log[ls]), 32'(8'h31));
`ifdef XOR_KEY_ROTATE_EN
      check("bp_second", 32'(out_log[ls+1]), 32'(8'h62));
`else
      check("bp_second", 32'(out_log[ls+1]), 32'(8'h01));
`endif
    end

    // key_load and in_valid in the same IDLE cycle
    ls = out_log.size();
    key_load = 1'b1;
    key_in = 8'h33;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    @(negedge clk);
    check("kl_blocks_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    key_load = 1'b0;
    @(negedge clk);
    check("kl_accept_next", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();
    if (out_log.size() > ls) check("kl_data", 32'(out_log[ls]), 32'(8'h22));
    else fail("kl_data");

    // timeout: core never answers
    bc0 = exp_count;
    core_dead = 1'b1;
    drop_mode = 1'b1;
    send_byte(8'h77);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      n++;
      hit = timeout_err;
    end
    if (!hit) fail("timeout_seen");
    check("timeout_window", 32'(n >= 32 && n <= 34), 32'(1));
    check("timeout_start_low", 32'(bus.core_start), 32'(0));
    check("timeout_no_out", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;
    drop_mode = 1'b0;
    core_dead = 1'b0;
    wait_idle();
    @(negedge clk);
    check("timeout_bc", 32'(byte_count), 32'(bc0));
    @(posedge clk);
    #1;
    ls = out_log.size();
    load_key(8'h0F);
    send_byte(8'h44);
    wait_idle();
    if (out_log.size() > ls) check("after_timeout_data", 32'(out_log[ls]), 32'(8'h4B));
    else fail("after_timeout_data");
    check("timeout_sticky", 32'(timeout_err), 32'(1));

`ifdef XOR_KEY_ROTATE_EN
    // rolling key
    ls = out_log.size();
    load_key(8'h81);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    wait_idle();
    check("rot_count", 32'(out_log.size() - ls), 32'(3));
    if (out_log.size() > ls + 2) begin
      check("rot_0", 32'(out_log[ls]), 32'(8'h81));
      check("rot_1", 32'(out_log[ls+1]), 32'(8'h03));
      check("rot_2", 32'(out_log[ls+2]), 32'(8'h06));
    end
`endif

    // reset in WAIT_DONE
    load_key(8'h5A);
    send_byte(8'h12);
    cycles(3);
    reset = 1'b1;
    #1;
    check("mid_rst_core_start", 32'(bus.core_start), 32'(0));
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_timeout", 32'(timeout_err), 32'(0));
    check("mid_rst_bc", 32'(byte_count), 32'(0));
    check("mid_rst_pt", 32'(bus.core_plaintext), 32'(0));
    check("mid_rst_key", 32'(bus.core_key), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(2);
    ls = out_log.size();
    load_key(8'h01);
    send_byte(8'hFE);
    wait_idle();
    if (out_log.size() > ls) check("post_rst_data", 32'(out_log[ls]), 32'(8'hFF));
    else fail("post_rst_data");

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_ctrl.md
Name: xor_stream_ctrl

Overview:
- Upstream sequencer for the bitwise XOR cipher core, which exposes start/plaintext/key/ciphertext/done.
- Accepts a stream of plaintext bytes on a valid/ready interface and drives the core's level-held start/done handshake one byte at a time.
- Captures each ciphertext byte into a one-entry output register and presents it downstream on valid/ready.
- Holds the session key and provides a timeout watchdog for a stalled core.

Parameters:
TIMEOUT_CYCLES, 32, cycles allowed in WAIT_DONE or WAIT_REL before abort; must be >= 16
CNT_W, 16, width of byte_count

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
key_load  in  1  load key_in into key register (honoured in IDLE only)
key_in  in  8  session key
in_valid  in  1  plaintext byte valid
in_data  in  8  plaintext byte
in_ready  out  1  controller accepts plaintext
out_valid  out  1  ciphertext byte valid
out_data  out  8  ciphertext byte
out_ready  in  1  downstream accepts
core_start  out  1  start to cipher core (level, registered)
core_plaintext  out  8  byte to core, stable while core_start high
core_key  out  8  key to core, stable while core_start high
core_ciphertext  in  8  core result
core_done  in  1  core done level
busy  out  1  state != IDLE or out_valid
timeout_err  out  1  sticky watchdog flag
byte_count  out  CNT_W  bytes delivered downstream

Behaviour:
- Reset: clk, reset asynchronous, active-high. All outputs 0; key register 0; state IDLE; watchdog counter 0.
- States: IDLE, WAIT_DONE, WAIT_REL.
- IDLE:
  - in_ready = (state==IDLE) && !key_load && !core_done.
  - key_load in IDLE: key_reg <= key_in. Simultaneous in_valid is not accepted that cycle.
  - key_load outside IDLE: ignored.
  - On in_valid&&in_ready: pt_reg <= in_data, core_key <= key_reg, core_start <= 1, go WAIT_DONE.
- WAIT_DONE:
  - Hold core_start=1; core_plaintext and core_key stable.
  - Output register empty (or emptying this cycle via out_ready): when core_done=1, out_data <= core_ciphertext, out_valid <= 1, core_start <= 0, go WAIT_REL.
  - Output register full with no handshake: remain in WAIT_DONE holding start high. The core holds its result while start is high, so backpressure is lossless.
- WAIT_REL:
  - core_start=0; wait for core_done=0, then go IDLE.
  - This guarantees a new start never overlaps a stale done.
- Output:
  - out_valid stays high until out_valid&&out_ready.
  - On handshake: clear out_valid and increment byte_count. byte_count wraps modulo 2^CNT_W.
  - Capture and handshake in the same cycle: register reloads, out_valid stays 1, byte_count +1.
- Watchdog:
  - Counter clears on every state change and counts each cycle in WAIT_DONE or WAIT_REL.
  - When it reaches TIMEOUT_CYCLES: timeout_err <= 1 (sticky until reset), core_start <= 0, byte discarded (no output, no count), go WAIT_REL.
  - Watchdog expiry in WAIT_REL: go IDLE anyway.
  - The watchdog does not count while output backpressure alone holds WAIT_DONE with core_done=1.
- Reset mid-operation: immediate return to reset values; core_start drops asynchronously; pending output is lost.
- core_done high while IDLE blocks in_ready.

Optional Feature:
- Macro XOR_KEY_ROTATE_EN.
- When defined: after each successful capture (not on timeout), key_reg <= {key_reg[6:0], key_reg[7]}, i.e. rotate left by 1, giving a per-byte rolling key. key_load resets the rotation.
- When undefined: key_reg changes only on key_load.

Decomposition:
- Shared package xor_cipher_pkg: state enum type (IDLE/WAIT_DONE/WAIT_REL), byte typedef, default TIMEOUT_CYCLES constant. Future cipher stages share it.
- One natural sub-module: xor_out_reg, the one-entry valid/ready output register with byte counter.

Test Plan:
- Key load and one byte: key_load key_in=0x5A, then in_data=0x3C with a behavioural core model (done 10 cycles after start) -> out_data=0x66, byte_count=1, core_start low within 1 cycle of capture.
- Streaming: 4 bytes 0x00,0xFF,0xA5,0x5A with key 0x0F and out_ready=1 -> outputs 0x0F,0xF0,0xAA,0x55 in order; in_ready low from acceptance until IDLE.
- Backpressure: out_ready=0 while second byte completes -> core_start held high, no output lost; release out_ready -> both bytes delivered in order.
- Timeout: core model never asserts done -> after 32 cycles timeout_err=1, core_start=0, no out_valid, byte_count unchanged; next byte still processed.
- Boundaries: key_load and in_valid in same IDLE cycle -> key updated, byte accepted next cycle. Reset asserted in WAIT_DONE -> all outputs 0 immediately.
- XOR_KEY_ROTATE_EN: key 0x81, plaintext 0x00 x3 -> outputs 0x81, 0x03, 0x06.
